// File: rtl/multicycle_shift_unit_if.sv
// Start/busy/done bus for the multi-cycle shifter.
// The master drives the request side and the slave (the shifter) drives the status side.
interface multicycle_shift_unit_if #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
);
  logic          start;
  logic          kill;
  logic [1:0]    mode;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  modport master (
    output start, kill, mode, a, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, mode, a, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/multicycle_shift_unit.sv
// Multi-cycle shifter for the EX stage: SLL/SRL/SRA/ROL by a run-time amount,
// STEP bits per cycle, with a start/busy/done handshake and a flush kill.
module multicycle_shift_unit #(
  parameter int N    = 32,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  multicycle_shift_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0]  M_SLL  = 2'b00;
  localparam logic [1:0]  M_SRL  = 2'b01;
  localparam logic [1:0]  M_SRA  = 2'b10;
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
  localparam logic [SW:0] N_W    = (SW+1)'(N);

  state_t        r_state;
  logic [N-1:0]  r_data;
  logic [N-1:0]  r_result;
  logic [SW-1:0] r_rem;
  logic [1:0]    r_mode;
  logic          r_busy;
  logic          r_done;

  logic [SW-1:0] w_s;
  logic [SW:0]   w_rot_back;
  logic [N-1:0]  w_next;

  // Per-cycle shift amount is min(STEP, remaining); the remainder never exceeds
  // N-1, so the STEP==N case always picks the remainder.
  always_comb begin
    w_s = r_rem;
    if ({1'b0, r_rem} >= STEP_W)
      w_s = STEP_W[SW-1:0];
  end

  // One shift step of the captured data by w_s in the captured mode.
  always_comb begin
    w_rot_back = N_W - {1'b0, w_s};
    w_next     = r_data;
    case (r_mode)
      M_SLL:   w_next = r_data << w_s;
      M_SRL:   w_next = r_data >> w_s;
      // Arithmetic shift keeps replicating the MSB captured at start.
      M_SRA:   w_next = N'($signed(r_data) >>> w_s);
      default: w_next = (r_data << w_s) | (r_data >> w_rot_back);
    endcase
  end

  // Control FSM plus data/remaining/result registers; reset beats kill beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_mode   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.kill) begin
      // Flush: drop whatever is in flight, keep the last completed result.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_data <= bus.a;
            r_mode <= bus.mode;
            r_rem  <= bus.shamt;
            r_busy <= 1'b1;
            if (bus.shamt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data <= w_next;
          r_rem  <= r_rem - w_s;
          if (r_rem == w_s) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          // Commit only when the done cycle was not killed (kill branch above).
          r_result <= r_data;
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // kill gates done combinationally so a flush in the DONE cycle never
  // presents a result; otherwise the fresh data is visible during done.
  assign bus.busy   = r_busy;
  assign bus.done   = r_done & ~bus.kill;
  assign bus.result = (r_done && !bus.kill) ? r_data : r_result;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Bench for multicycle_shift_unit: one STEP=1 and one STEP=4 instance, directed
// test-plan cases, randomized operations against a per-bit reference model,
// plus kill and reset-abort scenarios.
module tb_multicycle_shift_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  logic [31:0] prior [2];

  always #5 clk = ~clk;

  multicycle_shift_unit_if #(.N(32)) if0 ();
  multicycle_shift_unit_if #(.N(32)) if1 ();

  multicycle_shift_unit #(.N(32), .STEP(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  multicycle_shift_unit #(.N(32), .STEP(4)) u1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic st, input logic kl, input logic [1:0] m,
                       input logic [31:0] av, input logic [4:0] sh);
    if (u == 0) begin
      if0.start = st; if0.kill = kl; if0.mode = m; if0.a = av; if0.shamt = sh;
    end else begin
      if1.start = st; if1.kill = kl; if1.mode = m; if1.a = av; if1.shamt = sh;
    end
  endtask

  function automatic logic get_done(input int u);
    return (u == 0) ? if0.done : if1.done;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic [31:0] get_res(input int u);
    return (u == 0) ? if0.result : if1.result;
  endfunction

  // Reference: each output bit is picked from its source bit position.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] m, input int sh);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'd0: o[i] = (i >= sh) ? v[i - sh] : 1'b0;
        2'd1: o[i] = (i + sh < 32) ? v[i + sh] : 1'b0;
        2'd2: o[i] = (i + sh < 32) ? v[i + sh] : v[31];
        default: o[i] = v[(i - sh + 32) % 32];
      endcase
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation; noisy re-pulses start with junk operands while busy.
  task automatic op(input int u, input logic [31:0] av, input logic [1:0] m,
                    input logic [4:0] sh, input bit noisy);
    int          stp;
    int          lat;
    int          cyc;
    logic [31:0] exp;
    stp = (u == 0) ? 1 : 4;
    lat = (int'(sh) + stp - 1) / stp + 1;
    exp = ref_shift(av, m, int'(sh));
    drive(u, 1'b1, 1'b0, m, av, sh);
    step();
    drive(u, 1'b0, 1'b0, 2'($urandom), $urandom, 5'($urandom));
    cyc = 1;
    while (!get_done(u) && cyc < 100) begin
      chk("busy_in_flight", 32'(get_busy(u)), 32'd1);
      chk("result_hold_in_flight", get_res(u), prior[u]);
      if (noisy) drive(u, 1'($urandom), 1'b0, 2'($urandom), $urandom, 5'($urandom));
      step();
      drive(u, 1'b0, 1'b0, 2'($urandom), $urandom, 5'($urandom));
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("done_pulse", 32'(get_done(u)), 32'd1);
    chk("busy_in_done", 32'(get_busy(u)), 32'd1);
    chk("result", get_res(u), exp);
    prior[u] = exp;
    step();
    chk("done_one_cycle", 32'(get_done(u)), 32'd0);
    chk("busy_after", 32'(get_busy(u)), 32'd0);
    chk("result_held", get_res(u), exp);
  endtask

  initial begin
    prior[0] = '0;
    prior[1] = '0;
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("reset_busy", 32'(get_busy(u)), 32'd0);
      chk("reset_done", 32'(get_done(u)), 32'd0);
      chk("reset_result", get_res(u), 32'h0);
    end

    // Test-plan directed cases.
    op(0, 32'h0000_0001, 2'd0, 5'd12, 1'b0);
    op(0, 32'h8000_00F0, 2'd2, 5'd4, 1'b0);
    op(0, 32'h8000_00F0, 2'd1, 5'd4, 1'b0);
    op(1, 32'h1234_5678, 2'd3, 5'd8, 1'b0);
    op(1, 32'h0000_0001, 2'd0, 5'd5, 1'b0);
    op(1, 32'hDEAD_BEEF, 2'd1, 5'd0, 1'b0);
    op(0, 32'hDEAD_BEEF, 2'd3, 5'd31, 1'b1);
    op(1, 32'h8765_4321, 2'd2, 5'd31, 1'b1);
    // Back-to-back: start in the cycle right after done.
    op(0, 32'h0F0F_0001, 2'd3, 5'd1, 1'b1);

    // Randomized operations on both step sizes.
    for (int i = 0; i < 24; i++)
      op(i % 2, $urandom, 2'($urandom), 5'($urandom), 1'($urandom));

    // Kill in the 3rd SHIFT cycle, with a start in the same cycle.
    drive(0, 1'b1, 1'b0, 2'd0, 32'hA5A5_0001, 5'd20);
    step();
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    step();
    step();
    drive(0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 5'd3);
    #1;
    chk("kill_shift_done", 32'(if0.done), 32'd0);
    step();
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      chk("kill_shift_idle_busy", 32'(if0.busy), 32'd0);
      chk("kill_shift_no_done", 32'(if0.done), 32'd0);
      chk("kill_shift_result", if0.result, prior[0]);
      step();
    end

    // Kill arriving in the DONE cycle suppresses done and the result update.
    drive(0, 1'b1, 1'b0, 2'd3, 32'h1111_2222, 5'd0);
    step();
    chk("pre_kill_done", 32'(if0.done), 32'd1);
    drive(0, 1'b0, 1'b1, 2'd0, 32'h0, 5'd0);
    #1;
    chk("kill_done_gated", 32'(if0.done), 32'd0);
    chk("kill_done_result", if0.result, prior[0]);
    step();
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    chk("kill_done_busy", 32'(if0.busy), 32'd0);
    chk("kill_done_result_after", if0.result, prior[0]);
    step();
    chk("kill_done_no_done", 32'(if0.done), 32'd0);

    // Reset in the middle of an operation.
    drive(1, 1'b1, 1'b0, 2'd0, 32'h0000_00FF, 5'd31);
    step();
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    prior[0] = '0;
    prior[1] = '0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_busy", 32'(if1.busy), 32'd0);
      chk("rst_mid_done", 32'(if1.done), 32'd0);
      chk("rst_mid_result", if1.result, 32'h0);
      chk("rst_mid_result_u0", if0.result, 32'h0);
      step();
    end
    // Unit accepts a fresh start straight after reset.
    op(1, 32'hCAFE_F00D, 2'd3, 5'd13, 1'b0);
    op(0, 32'hCAFE_F00D, 2'd2, 5'd7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_shift_unit.md
Name: multicycle_shift_unit

Overview:
Parametrised multi-cycle shifter for the pipelined RISC-V datapath. It generalises the fixed single-shift-left, shift-left-12 and constant shift-right blocks into one unit:
- run-time shift amount
- four modes: SLL, SRL, SRA, ROL
- configurable number of bits shifted per cycle

It sits beside the ALU in EX and uses a start/busy/done handshake, so the hazard unit can stall the pipe while a shift is in flight. A kill input aborts the operation on a pipeline flush.

Parameters:
N, 32, data width in bits (power of 2, >= 8)
STEP, 1, bits shifted per cycle (power of 2, 1 <= STEP <= N)
SW, $clog2(N), shift-amount width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
kill  in  1  synchronous abort (pipeline flush)
mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
a  in  N  operand, captured on accepted start
shamt  in  SW  shift amount, captured on accepted start
busy  out  1  high in SHIFT and DONE states
done  out  1  one-cycle pulse, result valid
result  out  N  shifted value

Behaviour:
- Reset values: state IDLE, busy 0, done 0, result 0, internal data and remaining-count registers 0.
- Reset has priority over kill; kill has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, kill=0: capture a, mode and shamt.
  - shamt==0: go to DONE; data register = a.
  - otherwise: go to SHIFT; remaining = shamt.
- IDLE, start=0: stay in IDLE; result holds.
- SHIFT, each edge:
  - s = min(STEP, remaining).
  - SLL: data = data << s, zero fill.
  - SRL: data = data >> s, zero fill.
  - SRA: data = data >>> s, fill with captured bit N-1.
  - ROL: data = {data[N-1-s:0], data[N-1:N-s]}.
  - remaining -= s. When remaining becomes 0, go to DONE.
- DONE: done=1 and result = data for exactly one cycle, then go to IDLE.
- result holds its value until the next DONE or reset.
- Latency: k = ceil(shamt/STEP). done is high in the cycle k+1 edges after the accepting edge. Example: shamt=0 gives done in the cycle after start.
- Throughput: a new start is accepted only in IDLE, i.e. at the earliest in the cycle after done. start while busy is ignored; it is not queued.
- shamt is treated modulo N by construction (SW bits); the maximum shift is N-1.
- kill in SHIFT or DONE: go to IDLE next edge.
  - done is not pulsed; if kill arrives in DONE, done is forced 0 that cycle (kill is combinationally gated into done).
  - result keeps its previous completed value.
  - A start in the same cycle as kill is ignored.
- rst mid-operation: all state returns to reset values on the next edge; no done pulse.
- Inputs a, mode and shamt may change freely after capture without affecting the operation in flight.

Test Plan:
- N=32, STEP=1, SLL, a=0x0000_0001, shamt=12 -> busy 13 cycles; done pulse 13 cycles after start; result=0x0000_1000 (matches the legacy shift-left-12).
- N=32, STEP=1, SRA, a=0x8000_00F0, shamt=4 -> done after 5 cycles; result=0xF800_000F. Repeat with SRL -> result=0x0800_000F.
- N=32, STEP=4, ROL, a=0x1234_5678, shamt=8 -> done 3 cycles after start; result=0x3456_7812.
- N=32, STEP=4, shamt=5 -> final step s=1 (4+1); SLL a=0x1 -> result=0x20, done after 3 cycles. shamt=0 with a=0xDEAD_BEEF -> done next cycle; result=0xDEAD_BEEF.
- Handshake: start pulsed again while busy with different a -> ignored; first result intact. start in the cycle after done -> accepted.
- kill in 3rd SHIFT cycle, then rst in the middle of a second operation -> no done pulse in either case. After kill, result holds the prior value; after rst, result=0, busy=0, and state is IDLE next cycle.
